// File: rtl/tcs_color_scan_engine.sv
// TCS34725 colour scan engine.
// Brings the sensor up over a shared I2C master (ATIME, then ENABLE), then repeatedly reads
// NUM_CH consecutive 16-bit channel registers into a shadow buffer and publishes them
// atomically. Supports continuous or triggered single-shot scanning, an inter-scan holdoff,
// a per-transaction timeout and NACK recovery by re-initialising the sensor.
module tcs_color_scan_engine #(
   parameter int unsigned NUM_CH      = 4,
   parameter logic [6:0]  DEV_ADDR    = 7'h29,
   parameter logic [7:0]  BASE_REG    = 8'h14,
   parameter logic [7:0]  CMD_BIT     = 8'h80,
   parameter logic [7:0]  ATIME_VAL   = 8'hF6,
   parameter logic [7:0]  ENABLE_VAL  = 8'h03,
   parameter int unsigned TIMEOUT_CYC = 20000,
   parameter int unsigned PERIOD_CYC  = 1000
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   enable_i,
   input  logic                   single_shot_i,
   input  logic                   trigger_i,
   // I2C master request side
   output logic                   start_i2c_o,
   output logic                   rw_i2c_o,
   output logic [6:0]             dev_addr_o,
   output logic [7:0]             reg_addr_o,
   output logic [7:0]             wr_data_o,
   // I2C master response side
   input  logic                   done_i2c_i,
   input  logic                   busy_i2c_i,
   input  logic                   ack_err_i,
   input  logic [15:0]            data_in_i,
   // Published scan
   output logic [NUM_CH*16-1:0]   ch_data_o,
   output logic                   ready_o,
   output logic                   valid_o,
   output logic                   fault_o,
   output logic [7:0]             err_cnt_o
);

   // Counter widths; each counter only ever holds values up to its limit minus one.
   localparam int unsigned CW = (NUM_CH > 1)      ? $clog2(NUM_CH)      : 1;
   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int unsigned PW = (PERIOD_CYC > 1)  ? $clog2(PERIOD_CYC)  : 1;

   localparam logic [CW-1:0] LastCh   = CW'(NUM_CH - 1);
   localparam logic [TW-1:0] TmoLast  = TW'(TIMEOUT_CYC - 1);
   // Unused when PERIOD_CYC is zero because HOLDOFF is then never entered.
   localparam logic [PW-1:0] HoldLast = PW'(PERIOD_CYC - 1);

   localparam logic [7:0] RegEnable = 8'h00;
   localparam logic [7:0] RegAtime  = 8'h01;

   typedef enum logic [3:0] {
      StInitAt,
      StInitAtW,
      StInitEn,
      StInitEnW,
      StIdle,
      StIssue,
      StWait,
      StPublish,
      StHoldoff,
      StError
   } state_e;

   state_e                    state_q;
   logic [CW-1:0]             ch_q;
   logic [TW-1:0]             tmo_q;
   logic [PW-1:0]             hold_q;
   logic [NUM_CH-1:0][15:0]   shadow_q;

   logic                      start_q;
   logic                      rw_q;
   logic [7:0]                reg_addr_q;
   logic [7:0]                wr_data_q;
   logic [NUM_CH*16-1:0]      ch_data_q;
   logic                      ready_q;
   logic                      valid_q;
   logic                      fault_q;
   logic [7:0]                err_cnt_q;

   // Register address of the channel currently being scanned.
   logic [7:0]                ch_reg;
   assign ch_reg = CMD_BIT | (BASE_REG + 8'({ch_q, 1'b0}));

   // Sequencer: init writes, channel reads, publish, holdoff and error recovery.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StInitAt;
         ch_q       <= '0;
         tmo_q      <= '0;
         hold_q     <= '0;
         shadow_q   <= '0;
         start_q    <= 1'b0;
         rw_q       <= 1'b0;
         reg_addr_q <= 8'h00;
         wr_data_q  <= 8'h00;
         ch_data_q  <= '0;
         ready_q    <= 1'b0;
         valid_q    <= 1'b0;
         fault_q    <= 1'b0;
         err_cnt_q  <= 8'h00;
      end else begin
         // Pulses last exactly one cycle unless a state re-asserts them.
         start_q <= 1'b0;
         ready_q <= 1'b0;

         unique case (state_q)
            StInitAt: begin
               if (!busy_i2c_i) begin
                  start_q    <= 1'b1;
                  rw_q       <= 1'b1;
                  reg_addr_q <= CMD_BIT | RegAtime;
                  wr_data_q  <= ATIME_VAL;
                  tmo_q      <= '0;
                  state_q    <= StInitAtW;
               end
            end

            StInitAtW: begin
               // done_i2c wins over a coincident timeout.
               if (done_i2c_i) begin
                  state_q <= ack_err_i ? StError : StInitEn;
               end else if (tmo_q == TmoLast) begin
                  state_q <= StError;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end

            StInitEn: begin
               if (!busy_i2c_i) begin
                  start_q    <= 1'b1;
                  rw_q       <= 1'b1;
                  reg_addr_q <= CMD_BIT | RegEnable;
                  wr_data_q  <= ENABLE_VAL;
                  tmo_q      <= '0;
                  state_q    <= StInitEnW;
               end
            end

            StInitEnW: begin
               if (done_i2c_i) begin
                  state_q <= ack_err_i ? StError : StIdle;
               end else if (tmo_q == TmoLast) begin
                  state_q <= StError;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end

            StIdle: begin
               ch_q <= '0;
               // Triggers are only looked at here; elsewhere they are dropped.
               if (enable_i && (!single_shot_i || trigger_i)) begin
                  state_q <= StIssue;
               end
            end

            StIssue: begin
               if (!busy_i2c_i) begin
                  start_q    <= 1'b1;
                  rw_q       <= 1'b0;
                  reg_addr_q <= ch_reg;
                  tmo_q      <= '0;
                  state_q    <= StWait;
               end
            end

            StWait: begin
               if (done_i2c_i) begin
                  if (ack_err_i) begin
                     state_q <= StError;
                  end else begin
                     shadow_q[ch_q] <= data_in_i;
                     if (ch_q == LastCh) begin
                        state_q <= StPublish;
                     end else begin
                        ch_q    <= ch_q + 1'b1;
                        state_q <= StIssue;
                     end
                  end
               end else if (tmo_q == TmoLast) begin
                  state_q <= StError;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end

            StPublish: begin
               // Whole shadow moves in one cycle so consumers never see a mixed scan.
               ch_data_q <= shadow_q;
               ready_q   <= 1'b1;
               valid_q   <= 1'b1;
               fault_q   <= 1'b0;
               ch_q      <= '0;
               hold_q    <= '0;
               if (enable_i && !single_shot_i && (PERIOD_CYC > 0)) begin
                  state_q <= StHoldoff;
               end else begin
                  state_q <= StIdle;
               end
            end

            StHoldoff: begin
               if (hold_q == HoldLast) begin
                  state_q <= enable_i ? StIssue : StIdle;
               end else begin
                  hold_q <= hold_q + 1'b1;
               end
            end

            StError: begin
               // Partial scan stays in the shadow only; ch_data keeps the last good scan.
               fault_q <= 1'b1;
               if (err_cnt_q != 8'hFF) begin
                  err_cnt_q <= err_cnt_q + 8'd1;
               end
               ch_q    <= '0;
               state_q <= StInitAt;
            end

            default: begin
               state_q <= StInitAt;
            end
         endcase
      end
   end

   assign start_i2c_o = start_q;
   assign rw_i2c_o    = rw_q;
   assign dev_addr_o  = DEV_ADDR;
   assign reg_addr_o  = reg_addr_q;
   assign wr_data_o   = wr_data_q;
   assign ch_data_o   = ch_data_q;
   assign ready_o     = ready_q;
   assign valid_o     = valid_q;
   assign fault_o     = fault_q;
   assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_tcs_color_scan_engine.sv
// Scoreboard bench for tcs_color_scan_engine.
// Expected I2C transactions and expected published scans are queued by the stimulus
// process; independent monitors pop and compare when start_i2c or ready appear.
module tb_tcs_color_scan_engine;

   localparam int unsigned TMO = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        single_shot;
   logic        trigger;
   logic        start_i2c;
   logic        rw_i2c;
   logic [6:0]  dev_addr;
   logic [7:0]  reg_addr;
   logic [7:0]  wr_data;
   logic        done_i2c;
   logic        busy_i2c;
   logic        ack_err;
   logic [15:0] data_in;
   logic [63:0] ch_data;
   logic        ready;
   logic        valid;
   logic        fault;
   logic [7:0]  err_cnt;

   tcs_color_scan_engine #(
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .enable_i      (enable),
      .single_shot_i (single_shot),
      .trigger_i     (trigger),
      .start_i2c_o   (start_i2c),
      .rw_i2c_o      (rw_i2c),
      .dev_addr_o    (dev_addr),
      .reg_addr_o    (reg_addr),
      .wr_data_o     (wr_data),
      .done_i2c_i    (done_i2c),
      .busy_i2c_i    (busy_i2c),
      .ack_err_i     (ack_err),
      .data_in_i     (data_in),
      .ch_data_o     (ch_data),
      .ready_o       (ready),
      .valid_o       (valid),
      .fault_o       (fault),
      .err_cnt_o     (err_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic busy_at_edge = 1'b0;

   always @(posedge clk) begin
      cyc          <= cyc + 1;
      busy_at_edge <= busy_i2c;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- I2C master model ----------------
   int         m_cnt = 0;
   logic       m_busy = 1'b0;
   logic       force_busy = 1'b0;
   logic [7:0] m_reg = 8'h00;
   logic       m_rw = 1'b0;
   logic [7:0] tag = 8'h00;
   logic       nack_en = 1'b0;
   logic [7:0] nack_reg = 8'h00;
   logic       drop_next = 1'b0;

   assign busy_i2c = m_busy | force_busy;

   initial begin
      done_i2c = 1'b0;
      ack_err  = 1'b0;
      data_in  = 16'h0000;
      forever begin
         @(negedge clk);
         done_i2c = 1'b0;
         ack_err  = 1'b0;
         if (rst) begin
            m_cnt  = 0;
            m_busy = 1'b0;
         end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               done_i2c = 1'b1;
               m_busy   = 1'b0;
               data_in  = {tag, m_reg};
               if (nack_en && !m_rw && m_reg == nack_reg) begin
                  ack_err = 1'b1;
                  nack_en = 1'b0;
               end
            end
         end else if (start_i2c) begin
            if (drop_next) begin
               drop_next = 1'b0;
            end else begin
               m_cnt  = 10;
               m_busy = 1'b1;
               m_reg  = reg_addr;
               m_rw   = rw_i2c;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [16:0] txn_q[$];   // {rw, reg_addr, wr_data}
   logic [63:0] data_q[$];
   int          rdy_t[$];
   int          st_t[$];
   int          ready_cnt = 0;

   // Transaction monitor
   initial begin
      logic [16:0] e;
      forever begin
         @(negedge clk);
         if (!rst && start_i2c) begin
            st_t.push_back(cyc);
            chk("start_while_busy", 64'(busy_at_edge), 64'd0);
            chk("dev_addr", 64'(dev_addr), 64'h29);
            if (txn_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_start: got rw=%0b reg=%0h expected none", rw_i2c, reg_addr);
            end else begin
               e = txn_q.pop_front();
               chk("txn_rw_reg", 64'({rw_i2c, reg_addr}), 64'(e[16:8]));
               if (e[16]) chk("txn_wdata", 64'(wr_data), 64'(e[7:0]));
            end
         end
      end
   end

   // Publish monitor
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (!rst && ready) begin
            ready_cnt++;
            rdy_t.push_back(cyc);
            if (data_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_ready: got ch_data=%0h expected no publish", ch_data);
            end else begin
               e = data_q.pop_front();
               chk("ch_data", ch_data, e);
               chk("valid_on_ready", 64'(valid), 64'd1);
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic push_init();
      txn_q.push_back({1'b1, 8'h81, 8'hF6});
      txn_q.push_back({1'b1, 8'h80, 8'h03});
   endtask

   task automatic push_reads();
      txn_q.push_back({1'b0, 8'h94, 8'h00});
      txn_q.push_back({1'b0, 8'h96, 8'h00});
      txn_q.push_back({1'b0, 8'h98, 8'h00});
      txn_q.push_back({1'b0, 8'h9A, 8'h00});
   endtask

   task automatic pulse_trigger();
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
   endtask

   task automatic wait_ready(input int n, input int budget, input string name);
      int i = 0;
      while (ready_cnt < n && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk(name, 64'(ready_cnt >= n), 64'd1);
   endtask

   task automatic wait_txn_empty(input int budget, input string name);
      int i = 0;
      while (txn_q.size() != 0 && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk(name, 64'(txn_q.size()), 64'd0);
   endtask

   task automatic chk_reset_outputs(input string tag_s);
      chk({tag_s, "_start"},   64'(start_i2c), 64'd0);
      chk({tag_s, "_rw"},      64'(rw_i2c),    64'd0);
      chk({tag_s, "_dev"},     64'(dev_addr),  64'h29);
      chk({tag_s, "_reg"},     64'(reg_addr),  64'd0);
      chk({tag_s, "_wdata"},   64'(wr_data),   64'd0);
      chk({tag_s, "_chdata"},  ch_data,        64'd0);
      chk({tag_s, "_ready"},   64'(ready),     64'd0);
      chk({tag_s, "_valid"},   64'(valid),     64'd0);
      chk({tag_s, "_fault"},   64'(fault),     64'd0);
      chk({tag_s, "_errcnt"},  64'(err_cnt),   64'd0);
   endtask

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n0;
      int rel_t;
      int err_t;
      int i;
      rst         = 1'b1;
      enable      = 1'b0;
      single_shot = 1'b0;
      trigger     = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");

      // 1: init writes then one continuous scan; stop during holdoff
      push_init();
      push_reads();
      data_q.push_back(64'h119A_1198_1196_1194);
      tag    = 8'h11;
      enable = 1'b1;
      rst    = 1'b0;
      wait_ready(1, 400, "first_scan_ready");
      enable = 1'b0;
      chk("valid_after_first", 64'(valid), 64'd1);
      chk("fault_after_first", 64'(fault), 64'd0);
      repeat (1100) @(negedge clk);
      chk("parked_after_disable", 64'(ready_cnt), 64'd1);

      // 2: single-shot, one trigger gives exactly one scan
      single_shot = 1'b1;
      enable      = 1'b1;
      tag         = 8'h22;
      push_reads();
      data_q.push_back(64'h229A_2298_2296_2294);
      pulse_trigger();
      wait_ready(2, 400, "single_shot_ready");
      repeat (1500) @(negedge clk);
      chk("single_shot_once", 64'(ready_cnt), 64'd2);

      // 3: continuous; period = 1 publish + 1000 holdoff + 4 * (1 issue + 11 wait) = 1049
      tag = 8'h33;
      repeat (3) begin
         push_reads();
         data_q.push_back(64'h339A_3398_3396_3394);
      end
      single_shot = 1'b0;
      wait_ready(5, 4000, "continuous_ready");
      enable = 1'b0;
      if (rdy_t.size() >= 5) begin
         chk("period_1", 64'(rdy_t[3] - rdy_t[2]), 64'd1049);
         chk("period_2", 64'(rdy_t[4] - rdy_t[3]), 64'd1049);
      end
      repeat (1100) @(negedge clk);
      chk("continuous_stopped", 64'(ready_cnt), 64'd5);

      // 4: NACK on G read -> error, re-init, old data kept, next scan clears fault
      single_shot = 1'b1;
      enable      = 1'b1;
      tag         = 8'h44;
      nack_reg    = 8'h98;
      nack_en     = 1'b1;
      txn_q.push_back({1'b0, 8'h94, 8'h00});
      txn_q.push_back({1'b0, 8'h96, 8'h00});
      txn_q.push_back({1'b0, 8'h98, 8'h00});
      push_init();
      pulse_trigger();
      wait_txn_empty(300, "nack_reinit_done");
      repeat (20) @(negedge clk);
      chk("nack_fault", 64'(fault), 64'd1);
      chk("nack_errcnt", 64'(err_cnt), 64'd1);
      chk("nack_chdata_kept", ch_data, 64'h339A_3398_3396_3394);
      chk("nack_valid_kept", 64'(valid), 64'd1);
      chk("nack_no_ready", 64'(ready_cnt), 64'd5);
      tag = 8'h55;
      push_reads();
      data_q.push_back(64'h559A_5598_5596_5594);
      pulse_trigger();
      wait_ready(6, 400, "recover_ready");
      chk("recover_fault_clear", 64'(fault), 64'd0);
      chk("recover_errcnt", 64'(err_cnt), 64'd1);

      // 5: withheld done -> timeout; WAIT entered with start, ERROR 100 cycles later,
      //    err_cnt visible one cycle after that
      drop_next = 1'b1;
      txn_q.push_back({1'b0, 8'h94, 8'h00});
      push_init();
      n0 = st_t.size();
      pulse_trigger();
      i = 0;
      while (err_cnt != 8'd2 && i < 400) begin
         @(negedge clk);
         i++;
      end
      err_t = cyc;
      chk("timeout_errcnt", 64'(err_cnt), 64'd2);
      if (st_t.size() > n0) chk("timeout_latency", 64'(err_t - st_t[n0]), 64'd101);
      wait_txn_empty(300, "timeout_reinit_done");
      repeat (20) @(negedge clk);
      chk("timeout_fault", 64'(fault), 64'd1);
      chk("timeout_no_ready", 64'(ready_cnt), 64'd6);
      chk("timeout_chdata_kept", ch_data, 64'h559A_5598_5596_5594);

      // 6: busy held high before ISSUE delays start until release
      force_busy = 1'b1;
      tag        = 8'h77;
      push_reads();
      data_q.push_back(64'h779A_7798_7796_7794);
      n0 = st_t.size();
      pulse_trigger();
      repeat (50) @(negedge clk);
      chk("no_start_while_busy", 64'(st_t.size()), 64'(n0));
      rel_t      = cyc;
      force_busy = 1'b0;
      wait_ready(7, 400, "busy_scan_ready");
      if (st_t.size() > n0) chk("start_after_busy", 64'(st_t[n0] - rel_t), 64'd1);
      chk("busy_scan_fault_clear", 64'(fault), 64'd0);

      // 7: reset mid-WAIT -> outputs at reset values in the same cycle, no publish
      tag = 8'h88;
      txn_q.push_back({1'b0, 8'h94, 8'h00});
      pulse_trigger();
      wait_txn_empty(100, "mid_wait_start");
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      #1 chk_reset_outputs("midrst");
      @(negedge clk);
      @(negedge clk);
      push_init();
      rst = 1'b0;
      wait_txn_empty(300, "post_reset_init");
      repeat (20) @(negedge clk);
      chk("post_reset_no_ready", 64'(ready_cnt), 64'd7);
      chk("post_reset_valid", 64'(valid), 64'd0);
      chk("post_reset_chdata", ch_data, 64'd0);
      chk("leftover_scans", 64'(data_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
